// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the sysid probe master.
// Holds the FSM encoding, error codes and slave word map.
package sysid_probe_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    CHECK  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // ID mismatch outranks a timestamp mismatch.
  function automatic logic [1:0] check_code(
    input logic id_ok,
    input logic ts_ok
  );
    logic [1:0] code;
    code = ERR_NONE;
    if (!id_ok) begin
      code = ERR_ID;
    end else if (!ts_ok) begin
      code = ERR_TS;
    end
    return code;
  endfunction

endpackage

// File: rtl/sysid_probe_rdport.sv
// Single Avalon-MM read engine for the sysid probe.
// Owns the stall/timeout counter and the fixed-latency counter.
module sysid_probe_rdport #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        lat_i,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i,
  output logic        read_o,
  output logic        accept_o,
  output logic        timeout_o,
  output logic        cap_o,
  output logic [31:0] data_o
);

  localparam logic NO_LAT = (READ_LATENCY == 0);
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAT_LAST =
    2'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);

  logic [15:0] wait_q, wait_d;
  logic [1:0]  lat_q, lat_d;
  logic        stall;

  assign read_o    = req_i;
  assign stall     = req_i & waitrequest_i;
  assign accept_o  = req_i & ~waitrequest_i;
  assign timeout_o = stall & (wait_q == TO_LAST);
  assign data_o    = readdata_i;

  assign cap_o = NO_LAT ? accept_o
                        : (lat_i & (lat_q == LAT_LAST));

  // Stall count runs only while a read is stalled; latency count only in LAT_*.
  always_comb begin
    wait_d = '0;
    lat_d  = '0;
    if (stall && !timeout_o) begin
      wait_d = wait_q + 16'd1;
    end
    if (lat_i && !cap_o) begin
      lat_d = lat_q + 2'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
      lat_q  <= '0;
    end else begin
      wait_q <= wait_d;
      lat_q  <= lat_d;
    end
  end

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM master that reads sysid ID and timestamp words
// and checks them against the expected build values.
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic NO_LAT = (READ_LATENCY == 0);

  state_e      state_q, state_d;
  logic        pass_q, pass_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        tmo_q, tmo_d;

  logic        in_rd, in_lat;
  logic        accept, timeout, cap;
  logic [31:0] rdata;
  logic        id_ok, ts_ok;
  logic [1:0]  chk_err;

  assign in_rd  = (state_q == RD_ID) || (state_q == RD_TS);
  assign in_lat = (state_q == LAT_ID) || (state_q == LAT_TS);

  sysid_probe_rdport #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rdport (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .req_i         (in_rd),
    .lat_i         (in_lat),
    .waitrequest_i (avm_waitrequest),
    .readdata_i    (avm_readdata),
    .read_o        (avm_read),
    .accept_o      (accept),
    .timeout_o     (timeout),
    .cap_o         (cap),
    .data_o        (rdata)
  );

  assign avm_address = ((state_q == RD_TS) || (state_q == LAT_TS))
                     ? ADDR_TS : ADDR_ID;

  assign id_ok   = (id_q == EXPECTED_ID);
  assign ts_ok   = (EXPECTED_TS == 32'h0) || (ts_q == EXPECTED_TS);
  assign chk_err = check_code(id_ok, ts_ok);

  // Verdict is live during CHECK so it is valid alongside done.
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == CHECK) | tmo_q;
  assign pass       = (state_q == CHECK) ? (id_ok & ts_ok) : pass_q;
  assign error_code = (state_q == CHECK) ? chk_err : err_q;
  assign id_value   = id_q;
  assign ts_value   = ts_q;

  // Sequence the two reads, capture words, and latch the verdict.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    err_d   = err_q;
    id_d    = id_q;
    ts_d    = ts_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RD_ID;
      end
      RD_ID: begin
        if (timeout) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          err_d   = ERR_TIMEOUT;
          pass_d  = 1'b0;
        end else if (accept) begin
          state_d = NO_LAT ? RD_TS : LAT_ID;
        end
        if (cap) id_d = rdata;
      end
      LAT_ID: begin
        if (cap) begin
          id_d    = rdata;
          state_d = RD_TS;
        end
      end
      RD_TS: begin
        if (timeout) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          err_d   = ERR_TIMEOUT;
          pass_d  = 1'b0;
        end else if (accept) begin
          state_d = NO_LAT ? CHECK : LAT_TS;
        end
        if (cap) ts_d = rdata;
      end
      LAT_TS: begin
        if (cap) begin
          ts_d    = rdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        pass_d  = id_ok & ts_ok;
        err_d   = chk_err;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any read in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      err_q   <= ERR_NONE;
      id_q    <= '0;
      ts_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
